// File: rtl/noise_pattern_seq.sv
// Programmable beat-to-noise sequencer: beat counter, double-buffered per-channel
// segment masks, loop/one-shot playback and a gated Galois LFSR noise source.
module noise_pattern_seq #(
    parameter int                        BEAT_W       = 12,
    parameter int                        SEG_LEN_LOG2 = 2,
    parameter int                        NUM_SEG      = 16,
    parameter int                        NUM_CH       = 2,
    parameter logic [NUM_SEG-1:0]        DEFAULT_PAT  = 16'hFF0F,
    parameter logic [15:0]               LFSR_SEED    = 16'hACE1,
    localparam int                       CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                beat_tick,
    input  logic                restart,
    input  logic                loop_en,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [NUM_SEG-1:0]  cfg_pat,
    output logic [BEAT_W-1:0]   ibeatNum,
    output logic [NUM_CH-1:0]   is_noise,
    output logic [NUM_CH-1:0]   noise_bit,
    output logic                loop_done,
    output logic [NUM_CH-1:0]   pending
);

    localparam int SEG_W    = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
    localparam int END_BEAT = NUM_SEG << SEG_LEN_LOG2;
    localparam logic [BEAT_W-1:0] END_B  = BEAT_W'(END_BEAT);
    localparam logic [BEAT_W-1:0] LAST_B = BEAT_W'(END_BEAT - 1);

    generate
        if (END_BEAT >= (1 << BEAT_W)) begin : g_bad_beat_w
            $error("noise_pattern_seq: END_BEAT does not fit in BEAT_W bits");
        end
        if (LFSR_SEED == 16'h0000) begin : g_bad_seed
            $error("noise_pattern_seq: LFSR_SEED must be nonzero");
        end
    endgenerate

    // Galois right-shift step; taps B400 give a maximal-length sequence that never hits 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    logic [BEAT_W-1:0]  count;
    logic               done_hold;
    logic [15:0]        lfsr;
    logic [NUM_SEG-1:0] active [NUM_CH];
    logic [NUM_SEG-1:0] shadow [NUM_CH];
    logic [NUM_CH-1:0]  cfg_hit;
    logic [SEG_W-1:0]   seg;
    logic               step;
    logic               at_last;
    logic               commit;

    assign step    = en & beat_tick & ~done_hold & ~restart;
    assign at_last = (count == LAST_B);
    // Pattern swaps only happen at a boundary where no segment is mid-play.
    assign commit  = (step & at_last & loop_en) | restart | ~en;
    assign seg     = count[SEG_LEN_LOG2 +: SEG_W];

    always_comb begin
        cfg_hit   = '0;
        is_noise  = '0;
        noise_bit = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cfg_hit[c]   = cfg_we && (cfg_ch == CH_W'(c));
            is_noise[c]  = (count < END_B) && active[c][seg];
            noise_bit[c] = is_noise[c] & lfsr[c % 16];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            done_hold <= 1'b0;
            loop_done <= 1'b0;
        end else begin
            loop_done <= 1'b0;
            if (restart) begin
                count     <= '0;
                done_hold <= 1'b0;
            end else if (step) begin
                if (at_last) begin
                    loop_done <= 1'b1;
                    if (loop_en) begin
                        count <= '0;
                    end else begin
                        count     <= END_B;
                        done_hold <= 1'b1;
                    end
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                active[c] <= DEFAULT_PAT;
                shadow[c] <= DEFAULT_PAT;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (commit) begin
                    if (cfg_hit[c]) begin
                        active[c] <= cfg_pat;
                        shadow[c] <= cfg_pat;
                    end else if (pending[c]) begin
                        active[c] <= shadow[c];
                    end
                    pending[c] <= 1'b0;
                end else if (cfg_hit[c]) begin
                    shadow[c]  <= cfg_pat;
                    pending[c] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (en) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign ibeatNum = count;

endmodule

// File: tb/tb_noise_pattern_seq.sv
// Directed bench for noise_pattern_seq with hand-computed expectations.
module tb_noise_pattern_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        beat_tick = 1'b0;
    logic        restart = 1'b0;
    logic        loop_en = 1'b0;
    logic        cfg_we = 1'b0;
    logic [0:0]  cfg_ch = 1'b0;
    logic [15:0] cfg_pat = 16'h0000;
    logic [11:0] ibeatNum;
    logic [1:0]  is_noise;
    logic [1:0]  noise_bit;
    logic        loop_done;
    logic [1:0]  pending;

    int n_cmp = 0;
    int n_bad = 0;

    noise_pattern_seq dut (
        .clk(clk), .rst(rst), .en(en), .beat_tick(beat_tick), .restart(restart),
        .loop_en(loop_en), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_pat(cfg_pat),
        .ibeatNum(ibeatNum), .is_noise(is_noise), .noise_bit(noise_bit),
        .loop_done(loop_done), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        rst = 1'b1; en = 1'b0; beat_tick = 1'b0; restart = 1'b0;
        loop_en = 1'b0; cfg_we = 1'b0; cfg_ch = 1'b0; cfg_pat = 16'h0000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic do_tick();
        beat_tick = 1'b1;
        @(posedge clk);
        #1 beat_tick = 1'b0;
    endtask

    task automatic do_cfg(input logic ch, input logic [15:0] pat);
        cfg_we = 1'b1; cfg_ch = ch; cfg_pat = pat;
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (ibeatNum !== 12'd0) begin n_bad++; $display("FAIL reset_beat got %0d want 0", ibeatNum); end
        n_cmp++; if (pending !== 2'b00) begin n_bad++; $display("FAIL reset_pending got %b want 00", pending); end
        n_cmp++; if (loop_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", loop_done); end
        n_cmp++; if (is_noise !== 2'b11) begin n_bad++; $display("FAIL reset_is_noise got %b want 11", is_noise); end
        n_cmp++; if (noise_bit !== 2'b01) begin n_bad++; $display("FAIL reset_noise_bit got %b want 01", noise_bit); end
    endtask

    task automatic test_lfsr();
        // ACE1 -> E270 -> 7138 -> 389C -> 1C4E -> 0E27, low two bits shown
        logic [1:0] exp_nb [5] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b11};
        apply_reset();
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (noise_bit !== exp_nb[i]) begin n_bad++; $display("FAIL lfsr_step%0d got %b want %b", i + 1, noise_bit, exp_nb[i]); end
        end
    endtask

    task automatic test_oneshot();
        logic exp_n;
        int   pulses = 0;
        apply_reset();
        en = 1'b1; loop_en = 1'b0;
        for (int b = 0; b < 64; b++) begin
            exp_n = (b < 16) || (b >= 32);
            n_cmp++; if (ibeatNum !== 12'(b)) begin n_bad++; $display("FAIL oneshot_beat got %0d want %0d", ibeatNum, b); end
            n_cmp++; if (is_noise[0] !== exp_n) begin n_bad++; $display("FAIL oneshot_noise b%0d got %b want %b", b, is_noise[0], exp_n); end
            do_tick();
            if (loop_done) pulses++;
            if (b == 63) begin
                n_cmp++; if (loop_done !== 1'b1) begin n_bad++; $display("FAIL oneshot_done_pulse got %b want 1", loop_done); end
            end
        end
        n_cmp++; if (ibeatNum !== 12'd64) begin n_bad++; $display("FAIL oneshot_hold got %0d want 64", ibeatNum); end
        n_cmp++; if (is_noise !== 2'b00) begin n_bad++; $display("FAIL oneshot_end_noise got %b want 00", is_noise); end
        for (int i = 0; i < 3; i++) begin
            do_tick();
            if (loop_done) pulses++;
        end
        n_cmp++; if (ibeatNum !== 12'd64) begin n_bad++; $display("FAIL oneshot_ignore got %0d want 64", ibeatNum); end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL oneshot_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_loop();
        int pulses = 0;
        apply_reset();
        en = 1'b1; loop_en = 1'b1;
        for (int t = 1; t <= 130; t++) begin
            do_tick();
            if (loop_done) pulses++;
            if (t == 64 || t == 128) begin
                n_cmp++; if (ibeatNum !== 12'd0) begin n_bad++; $display("FAIL loop_wrap t%0d got %0d want 0", t, ibeatNum); end
            end
        end
        n_cmp++; if (pulses !== 2) begin n_bad++; $display("FAIL loop_pulses got %0d want 2", pulses); end
        n_cmp++; if (ibeatNum !== 12'd2) begin n_bad++; $display("FAIL loop_final got %0d want 2", ibeatNum); end
    endtask

    task automatic test_pending();
        apply_reset();
        en = 1'b1; loop_en = 1'b1;
        repeat (10) do_tick();
        do_cfg(1'b1, 16'h0001);
        n_cmp++; if (pending !== 2'b10) begin n_bad++; $display("FAIL pend_set got %b want 10", pending); end
        n_cmp++; if (is_noise[1] !== 1'b1) begin n_bad++; $display("FAIL pend_b10 got %b want 1", is_noise[1]); end
        repeat (30) do_tick();
        n_cmp++; if (ibeatNum !== 12'd40) begin n_bad++; $display("FAIL pend_beat40 got %0d want 40", ibeatNum); end
        n_cmp++; if (is_noise[1] !== 1'b1) begin n_bad++; $display("FAIL pend_b40_old got %b want 1", is_noise[1]); end
        n_cmp++; if (pending !== 2'b10) begin n_bad++; $display("FAIL pend_held got %b want 10", pending); end
        repeat (24) do_tick();
        n_cmp++; if (ibeatNum !== 12'd0) begin n_bad++; $display("FAIL pend_wrap got %0d want 0", ibeatNum); end
        n_cmp++; if (is_noise[1] !== 1'b1) begin n_bad++; $display("FAIL pend_b0_new got %b want 1", is_noise[1]); end
        n_cmp++; if (pending !== 2'b00) begin n_bad++; $display("FAIL pend_clear got %b want 00", pending); end
        repeat (4) do_tick();
        n_cmp++; if (is_noise !== 2'b01) begin n_bad++; $display("FAIL pend_b4 got %b want 01", is_noise); end
    endtask

    task automatic test_restart();
        apply_reset();
        en = 1'b1; loop_en = 1'b1;
        repeat (37) do_tick();
        do_cfg(1'b0, 16'h0002);
        n_cmp++; if (pending !== 2'b01) begin n_bad++; $display("FAIL rst_pend got %b want 01", pending); end
        restart = 1'b1; beat_tick = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0; beat_tick = 1'b0;
        n_cmp++; if (ibeatNum !== 12'd0) begin n_bad++; $display("FAIL restart_beat got %0d want 0", ibeatNum); end
        n_cmp++; if (pending !== 2'b00) begin n_bad++; $display("FAIL restart_commit got %b want 00", pending); end
        n_cmp++; if (is_noise !== 2'b10) begin n_bad++; $display("FAIL restart_b0 got %b want 10", is_noise); end
        repeat (4) do_tick();
        n_cmp++; if (is_noise !== 2'b11) begin n_bad++; $display("FAIL restart_b4 got %b want 11", is_noise); end
    endtask

    task automatic test_freeze();
        apply_reset();
        en = 1'b1;
        repeat (5) do_tick();
        n_cmp++; if (noise_bit !== 2'b11) begin n_bad++; $display("FAIL frz_pre got %b want 11", noise_bit); end
        en = 1'b0; beat_tick = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cfg_we = (i == 2); cfg_ch = 1'b1; cfg_pat = 16'h0000;
            @(posedge clk); #1;
            n_cmp++; if (ibeatNum !== 12'd5) begin n_bad++; $display("FAIL frz_beat c%0d got %0d want 5", i, ibeatNum); end
            n_cmp++; if (pending !== 2'b00) begin n_bad++; $display("FAIL frz_pend c%0d got %b want 00", i, pending); end
        end
        cfg_we = 1'b0; beat_tick = 1'b0;
        n_cmp++; if (is_noise !== 2'b01) begin n_bad++; $display("FAIL frz_commit got %b want 01", is_noise); end
        n_cmp++; if (noise_bit !== 2'b01) begin n_bad++; $display("FAIL frz_lfsr got %b want 01", noise_bit); end
        en = 1'b1;
        @(posedge clk); #1;
        // 0E27 -> B313: bit0 stays 1, channel 1 gated off
        n_cmp++; if (noise_bit !== 2'b01) begin n_bad++; $display("FAIL frz_resume got %b want 01", noise_bit); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        en = 1'b1; loop_en = 1'b1;
        repeat (50) do_tick();
        do_cfg(1'b0, 16'h0000);
        n_cmp++; if (ibeatNum !== 12'd50) begin n_bad++; $display("FAIL arst_pre got %0d want 50", ibeatNum); end
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (ibeatNum !== 12'd0) begin n_bad++; $display("FAIL arst_beat got %0d want 0", ibeatNum); end
        n_cmp++; if (pending !== 2'b00) begin n_bad++; $display("FAIL arst_pend got %b want 00", pending); end
        n_cmp++; if (is_noise !== 2'b11) begin n_bad++; $display("FAIL arst_noise got %b want 11", is_noise); end
        n_cmp++; if (noise_bit !== 2'b01) begin n_bad++; $display("FAIL arst_lfsr got %b want 01", noise_bit); end
        n_cmp++; if (loop_done !== 1'b0) begin n_bad++; $display("FAIL arst_done got %b want 0", loop_done); end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (16) do_tick();
        n_cmp++; if (is_noise !== 2'b00) begin n_bad++; $display("FAIL arst_pat_b16 got %b want 00", is_noise); end
    endtask

    initial begin
        test_reset();
        test_lfsr();
        test_oneshot();
        test_loop();
        test_pending();
        test_restart();
        test_freeze();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/noise_pattern_seq.md
Name: noise_pattern_seq

Overview:
- Parametrised, programmable successor to the fixed beat-to-noise lookup in the music player.
- Owns its own beat counter and a per-channel segment mask, with double-buffered runtime reprogramming.
- Supports loop or one-shot playback.
- Provides an LFSR noise source gated per channel. It sits between the beat-tick generator and the audio mixer.

Parameters:
- BEAT_W, 12, width of the beat counter and ibeatNum output.
- SEG_LEN_LOG2, 2, log2 of beats per segment (4 beats per segment).
- NUM_SEG, 16, segments per pattern; END_BEAT = NUM_SEG << SEG_LEN_LOG2 (64 by default).
- NUM_CH, 2, number of independent noise channels (≥1).
- DEFAULT_PAT, 16'hFF0F, reset pattern loaded into every channel; bit i = segment i.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; gates beat advance and the LFSR.
- beat_tick  in  1  single-cycle pulse; advances the beat counter by one.
- restart  in  1  single-cycle pulse; returns the beat counter to 0.
- loop_en  in  1  1 = wrap at END_BEAT, 0 = one-shot stop.
- cfg_we  in  1  pattern write strobe.
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel for the write.
- cfg_pat  in  NUM_SEG  new pattern for the channel.
- ibeatNum  out  BEAT_W  current beat counter value.
- is_noise  out  NUM_CH  per-channel noise-active flag.
- noise_bit  out  NUM_CH  gated pseudo-random noise sample.
- loop_done  out  1  one-cycle pulse when the pattern end is reached.
- pending  out  NUM_CH  shadow pattern awaiting commit.

Behaviour:
- Reset (async, immediate):
  - ibeatNum = 0; loop_done = 0; pending = 0.
  - active and shadow patterns = DEFAULT_PAT on every channel.
  - LFSR = LFSR_SEED; done_hold = 0.
- Beat counter, priority order per cycle:
  1. rst.
  2. restart: count ← 0, done_hold ← 0. Takes effect regardless of en, and over a coincident beat_tick.
  3. en & beat_tick & ~done_hold:
     - If count == END_BEAT-1 and loop_en: count ← 0, loop_done pulses 1 cycle.
     - If count == END_BEAT-1 and ~loop_en: count ← END_BEAT, done_hold ← 1, loop_done pulses 1 cycle.
     - Otherwise: count ← count+1.
  4. Otherwise hold.
- Once done_hold is set, ticks are ignored until restart.
- Changing loop_en mid-pattern takes effect at the next end-of-pattern decision only.
- is_noise[c]:
  - Combinational from registered state: active[c][count >> SEG_LEN_LOG2] when count < END_BEAT, else 0.
  - Zero latency relative to ibeatNum.
  - Never glitches from inputs.
- Config, double-buffered:
  - cfg_we writes shadow[cfg_ch] ← cfg_pat and sets pending[cfg_ch].
  - cfg_ch ≥ NUM_CH: write ignored.
- Commit: on a commit event, every channel with pending set copies shadow→active and clears pending. Commit events are:
  - a wrap to 0 (loop mode),
  - restart,
  - any cycle with en = 0.
- A cfg_we coinciding with a commit event commits cfg_pat for that channel directly; pending ends 0 for it.
- Active patterns never change mid-pattern while running.
- LFSR:
  - 16-bit Galois, right-shift, taps 16'hB400.
  - Advances every clk while en = 1; holds when en = 0.
  - noise_bit[c] = is_noise[c] & lfsr[c mod 16].
  - The state can never reach 0.
- Width rules:
  - END_BEAT must be < 2^BEAT_W. Elaboration fails via generate-time check otherwise.
  - Segment index is count[SEG_LEN_LOG2 +: $clog2(NUM_SEG)].

Test Plan:
- Reset, then 64 ticks with defaults and loop_en = 0:
  - is_noise[0] = 1 for beats 0–15, 0 for 16–31, 1 for 32–63.
  - loop_done pulses once at the 64th tick.
  - ibeatNum holds at 64 with is_noise = 0; further ticks are ignored.
- loop_en = 1, 130 ticks:
  - ibeatNum wraps 63→0 twice.
  - loop_done pulses exactly twice; final ibeatNum = 2.
- Running at beat 10, cfg_we ch1 pattern 16'h0001:
  - pending[1] = 1 immediately.
  - is_noise[1] is unchanged until the wrap; at beat 0 it becomes 1 and pending[1] clears.
- restart and beat_tick asserted in the same cycle at beat 37:
  - ibeatNum = 0 next cycle.
  - A pending shadow is committed.
- en = 0 for 5 cycles:
  - LFSR and ibeatNum frozen.
  - A cfg_we during this window commits immediately; pending stays 0.
- Assert rst mid-pattern at beat 50, asynchronously between edges:
  - All outputs return to their reset values at once.
  - Patterns revert to 16'hFF0F; LFSR = 16'hACE1.
